// File: rtl/ma_pkg.sv
// Shared definitions for the inverse moving-sum filter: FSM encoding,
// a width helper and saturation limits derived from the output width.
package ma_pkg;

  typedef enum logic [1:0] {
    ST_IN    = 2'b00,
    ST_CALC  = 2'b01,
    ST_SHIFT = 2'b10
  } state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((32'sd1 <<< res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

  function automatic longint sat_max(input int data_w);
    return (64'sd1 <<< (data_w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int data_w);
    return -(64'sd1 <<< (data_w - 1));
  endfunction

endpackage

// File: rtl/ma_hist_sr.sv
// N-entry history of recovered samples; tail is the sample from N steps ago.
module ma_hist_sr #(
  parameter int N = 3,
  parameter int W = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_en,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] tail
);

  logic signed [W-1:0] hist_q [N];
  logic signed [W-1:0] hist_d [N];

  always_comb begin
    hist_d = hist_q;
    if (shift_en) begin
      hist_d[0] = din;
      for (int k = 1; k < N; k++) begin
        hist_d[k] = hist_q[k-1];
      end
    end else begin
      hist_d = hist_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '{default: '0};
    end else begin
      hist_q <= hist_d;
    end
  end

  assign tail = hist_q[N-1];

endmodule

// File: rtl/ma_inv.sv
// Inverse moving-sum filter: x[n] = S[n] - S[n-1] + x[n-N], three enabled
// cycles per sample, saturated output with overflow flag.
module ma_inv
  import ma_pkg::*;
#(
  parameter int MA_ARRAY_LENGTH = 3,
  parameter int DATA_W          = 16,
  parameter int SUM_W           = DATA_W + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [SUM_W-1:0]  in_sum,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_ovf
);

  localparam logic signed [SUM_W:0] MAX_S = (SUM_W+1)'(sat_max(DATA_W));
  localparam logic signed [SUM_W:0] MIN_S = (SUM_W+1)'(sat_min(DATA_W));

  state_e                    state_q, state_d;
  logic signed [SUM_W-1:0]   s_prev_q, s_prev_d;
  logic signed [SUM_W-1:0]   s_cur_q, s_cur_d;
  logic signed [SUM_W:0]     x_calc_q, x_calc_d;
  logic signed [DATA_W-1:0]  out_data_q, out_data_d;
  logic                      out_ovf_q, out_ovf_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [SUM_W-1:0]   tail_s;
  logic                      shift_en_s;

  ma_hist_sr #(.N(MA_ARRAY_LENGTH), .W(SUM_W)) u_hist (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en_s),
    .din      (x_calc_q[SUM_W-1:0]),
    .tail     (tail_s)
  );

  always_comb begin
    state_d     = state_q;
    s_prev_d    = s_prev_q;
    s_cur_d     = s_cur_q;
    x_calc_d    = x_calc_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = 1'b0;
    in_ready    = 1'b0;
    shift_en_s  = 1'b0;
    if (en) begin
      case (state_q)
        ST_IN: begin
          in_ready = 1'b1;
          if (in_valid) begin
            s_cur_d = in_sum;
            state_d = ST_CALC;
          end else begin
            state_d = ST_IN;
          end
        end
        ST_CALC: begin
          // One extra bit keeps the difference-plus-history free of wrap.
          x_calc_d = {s_cur_q[SUM_W-1], s_cur_q} - {s_prev_q[SUM_W-1], s_prev_q}
                     + {tail_s[SUM_W-1], tail_s};
          state_d  = ST_SHIFT;
        end
        ST_SHIFT: begin
          shift_en_s  = 1'b1;
          s_prev_d    = s_cur_q;
          out_valid_d = 1'b1;
          if (x_calc_q > MAX_S) begin
            out_data_d = MAX_S[DATA_W-1:0];
            out_ovf_d  = 1'b1;
          end else if (x_calc_q < MIN_S) begin
            out_data_d = MIN_S[DATA_W-1:0];
            out_ovf_d  = 1'b1;
          end else begin
            out_data_d = x_calc_q[DATA_W-1:0];
            out_ovf_d  = 1'b0;
          end
          state_d = ST_IN;
        end
        default: begin
          state_d = ST_IN;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IN;
      s_prev_q    <= '0;
      s_cur_q     <= '0;
      x_calc_q    <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_prev_q    <= s_prev_d;
      s_cur_q     <= s_cur_d;
      x_calc_q    <= x_calc_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_ma_inv.sv
// Directed self-checking bench for ma_inv with N=3, DATA_W=16, SUM_W=18.
module tb_ma_inv;

  logic               clk;
  logic               rst;
  logic               en;
  logic               in_valid;
  logic               in_ready;
  logic signed [17:0] in_sum;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               out_ovf;

  int checks;
  int errors;

  ma_inv #(.MA_ARRAY_LENGTH(3), .DATA_W(16), .SUM_W(18)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the FSM in ST_IN; returns at a falling edge
  // where the resulting output pulse is visible.
  task automatic send(input int s, input int exp_d, input logic exp_ovf,
                      input int stall);
    logic signed [15:0] held;
    in_valid = 1'b1;
    in_sum   = 18'(s);
    chk("in_ready_idle", in_ready, 1);
    held = out_data;
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (stall > 0) en = 1'b0;
    @(negedge clk);
    chk("valid_after_accept", out_valid, 0);
    repeat (stall) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", out_valid, 0);
      chk("stall_ready", in_ready, 0);
      chk("stall_data_hold", out_data, held);
    end
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("valid_in_shift", out_valid, 0);
    chk("ready_in_shift", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, exp_d);
    chk("out_ovf", out_ovf, exp_ovf);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    en       = 1'b1;
    in_valid = 1'b0;
    in_sum   = '0;
    #2;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", out_ovf, 0);
    @(negedge clk);
    rst = 1'b1;

    // Ramp: sums 1,3,6,9,12 recover 1..5
    send(1, 1, 1'b0, 0);
    send(3, 2, 1'b0, 0);
    send(6, 3, 1'b0, 0);
    send(9, 4, 1'b0, 0);
    send(12, 5, 1'b0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("pulse_single_cycle", out_valid, 0);

    // Same ramp with a 5-cycle enable stall while in ST_CALC
    apply_reset();
    send(1, 1, 1'b0, 0);
    send(3, 2, 1'b0, 0);
    send(6, 3, 1'b0, 5);
    send(9, 4, 1'b0, 0);
    send(12, 5, 1'b0, 0);

    // Signed samples
    apply_reset();
    send(-5, -5, 1'b0, 0);
    send(2, 7, 1'b0, 0);
    send(0, -2, 1'b0, 0);
    send(5, 0, 1'b0, 0);
    send(98, 100, 1'b0, 0);

    // Saturation; x3 = 0 only if history kept the unsaturated 40000
    apply_reset();
    send(40000, 32767, 1'b1, 0);
    send(40000, 0, 1'b0, 0);
    send(40000, 0, 1'b0, 0);
    send(0, 0, 1'b0, 0);
    send(0, 0, 1'b0, 0);
    send(100000, 32767, 1'b1, 0);
    send(100000, 0, 1'b0, 0);
    apply_reset();
    send(-40000, -32768, 1'b1, 0);
    send(-40000, 0, 1'b0, 0);

    // Asynchronous reset between edges with a sum in flight
    apply_reset();
    send(1, 1, 1'b0, 0);
    send(3, 2, 1'b0, 0);
    in_valid = 1'b1;
    in_sum   = 18'sd6;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_data", out_data, 0);
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    send(4, 4, 1'b0, 0);
    send(9, 5, 1'b0, 0);

    // in_valid held high: one acceptance per three cycles
    apply_reset();
    in_valid = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      case (c)
        0:       in_sum = 18'sd1;
        3:       in_sum = 18'sd3;
        6:       in_sum = 18'sd6;
        9:       in_sum = 18'sd9;
        default: in_sum = 18'sd777;
      endcase
      chk("bp_ready", in_ready, ((c % 3) == 0) ? 1 : 0);
      chk("bp_valid", out_valid, (((c % 3) == 0) && (c > 0)) ? 1 : 0);
      if (c == 3) chk("bp_data1", out_data, 1);
      if (c == 6) chk("bp_data2", out_data, 2);
      if (c == 9) chk("bp_data3", out_data, 3);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
